// File: rtl/video_timing_pkg.sv
// Shared video-timing definitions.
//   state_t           : control-state encoding for the delay measurement block
//   DEFAULT_MAX_DELAY : default saturation/timeout limit, also used by the
//                       programmable delay lines that consume the measurement
package video_timing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_COUNT,
    ST_ACC,
    ST_DONE
  } state_t;

  localparam int DEFAULT_MAX_DELAY = 255;

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector for a signal already synchronous to clk.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   d    : input level
//   rise : high in the cycle where d is 1 and was 0 in the previous cycle
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order of always blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/signal_delay_measure.sv
// Measures the skew, in clk cycles, between a rising edge on ref_in and the
// next rising edge on sig_in, optionally averaging 2^AVG_LOG2 measurements.
//   clk         : system clock
//   rst         : asynchronous active-high reset; aborts any run in progress
//   ref_in      : reference signal
//   sig_in      : delayed copy of the reference
//   start       : one-cycle request to begin a run (ignored unless idle)
//   busy        : high while a run is in progress
//   delay_valid : one-cycle pulse when delay_out/timeout are updated
//   delay_out   : averaged delay, held until the next result
//   timeout     : set with delay_valid if any sample of the run saturated
module signal_delay_measure
  import video_timing_pkg::*;
#(
  parameter int MAX_DELAY   = DEFAULT_MAX_DELAY,
  parameter int COUNT_WIDTH = 8,
  parameter int AVG_LOG2    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ref_in,
  input  logic                   sig_in,
  input  logic                   start,
  output logic                   busy,
  output logic                   delay_valid,
  output logic [COUNT_WIDTH-1:0] delay_out,
  output logic                   timeout
);

  // Accumulator is wide enough for 2^AVG_LOG2 samples of MAX_DELAY each.
  localparam int ACC_W = COUNT_WIDTH + AVG_LOG2;
  localparam int IDX_W = AVG_LOG2 + 1;
  localparam logic [IDX_W-1:0]       N_SAMPLES = IDX_W'(2 ** AVG_LOG2);
  localparam logic [COUNT_WIDTH-1:0] MAX_CNT   = COUNT_WIDTH'(MAX_DELAY);

  state_t state, next_state;

  logic                   ref_rise, sig_rise;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] sample;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_sum;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_next;
  logic                   timeout_acc;
  logic                   last_sample;

  edge_detect_rise u_ref_edge (.clk(clk), .rst(rst), .d(ref_in), .rise(ref_rise));
  edge_detect_rise u_sig_edge (.clk(clk), .rst(rst), .d(sig_in), .rise(sig_rise));

  assign acc_sum     = acc + ACC_W'(sample);
  assign idx_next    = idx + 1'b1;
  assign last_sample = (idx_next == N_SAMPLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    busy        = 1'b0;
    delay_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_ARM;
      end
      ST_ARM: begin
        busy = 1'b1;
        // A sig edge without a ref edge is ignored: we only anchor on ref.
        if (ref_rise) next_state = sig_rise ? ST_ACC : ST_COUNT;
      end
      ST_COUNT: begin
        busy = 1'b1;
        if (sig_rise || cnt == MAX_CNT) next_state = ST_ACC;
      end
      ST_ACC: begin
        busy       = 1'b1;
        next_state = last_sample ? ST_DONE : ST_ARM;
      end
      ST_DONE: begin
        delay_valid = 1'b1;
        next_state  = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // NOTE: all datapath registers, including the result holding registers,
  // are reset so outputs read 0 immediately on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      sample      <= '0;
      acc         <= '0;
      idx         <= '0;
      timeout_acc <= 1'b0;
      delay_out   <= '0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc         <= '0;
            idx         <= '0;
            timeout_acc <= 1'b0;
          end
        end
        ST_ARM: begin
          if (ref_rise) begin
            if (sig_rise) sample <= '0;
            else          cnt    <= COUNT_WIDTH'(1);
          end
        end
        ST_COUNT: begin
          // sig edge wins over saturation when both land on MAX_DELAY.
          if (sig_rise) begin
            sample <= cnt;
          end else if (cnt == MAX_CNT) begin
            sample      <= MAX_CNT;
            timeout_acc <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACC: begin
          acc <= acc_sum;
          idx <= idx_next;
          // Load the result here so it is already stable during the DONE
          // cycle in which delay_valid is high.
          if (last_sample) begin
            delay_out <= COUNT_WIDTH'(acc_sum >> AVG_LOG2);
            timeout   <= timeout_acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
